// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and memory-side bus bundle around the OAM DMA sequencer; combinational wiring only.
// No flow control of its own: the DMA owner stalls the CPU through cpu_halt.
interface oam_dma_ctrl_if;
   logic [15:0] cpu_mem_addr;
   logic [7:0]  cpu_data_out;
   logic        cpu_write_en;
   logic        cpu_read_en;
   logic        cpu_halt;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data_wr;
   logic        mem_write_en;
   logic        mem_read_en;
   logic [7:0]  mem_data_rd;
   logic        dma_busy;

   modport slave (
      input  cpu_mem_addr, cpu_data_out, cpu_write_en, cpu_read_en, mem_data_rd,
      output cpu_halt, mem_addr, mem_data_wr, mem_write_en, mem_read_en, dma_busy
   );

   modport master (
      output cpu_mem_addr, cpu_data_out, cpu_write_en, cpu_read_en, mem_data_rd,
      input  cpu_halt, mem_addr, mem_data_wr, mem_write_en, mem_read_en, dma_busy
   );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA: copies one source page to the OAM data port, owning the shared bus meanwhile.
// Pass-through is combinational; a transfer stalls the CPU 1+2*XFER_LEN cycles (+1 on odd parity).
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
   parameter int          XFER_LEN      = 256
) (
   input  logic           clk,
   input  logic           rst,
   oam_dma_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HALT  = 3'd1,
      S_ALIGN = 3'd2,
      S_READ  = 3'd3,
      S_WRITE = 3'd4
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] idx;
   logic [7:0] page;
   logic       par;
   logic       trigger;

   // Only a write strobe starts a transfer; reads of the register are ignored.
   assign trigger = bus.cpu_write_en && (bus.cpu_mem_addr == DMA_REG_ADDR);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         idx   <= 8'd0;
         page  <= 8'd0;
         par   <= 1'b0;
      end else begin
         par   <= ~par;
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (trigger) begin
                  page <= bus.cpu_data_out;
                  idx  <= 8'd0;
               end
            end
            S_WRITE: idx <= (idx == LAST_IDX) ? 8'd0 : idx + 8'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (trigger) state_nxt = S_HALT;
         S_HALT:  state_nxt = par ? S_ALIGN : S_READ;
         S_ALIGN: state_nxt = S_READ;
         S_READ:  state_nxt = S_WRITE;
         S_WRITE: state_nxt = (idx == LAST_IDX) ? S_IDLE : S_READ;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.mem_addr     = 16'h0000;
      bus.mem_data_wr  = 8'h00;
      bus.mem_write_en = 1'b0;
      bus.mem_read_en  = 1'b0;
      bus.cpu_halt     = (state != S_IDLE);
      bus.dma_busy     = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            bus.mem_addr     = bus.cpu_mem_addr;
            bus.mem_data_wr  = bus.cpu_data_out;
            bus.mem_write_en = bus.cpu_write_en;
            bus.mem_read_en  = bus.cpu_read_en;
         end
         S_READ: begin
            bus.mem_addr    = {page, idx};
            bus.mem_read_en = 1'b1;
         end
         // Read data arrives one cycle after the READ address, i.e. now.
         S_WRITE: begin
            bus.mem_addr     = OAM_DATA_ADDR;
            bus.mem_data_wr  = bus.mem_data_rd;
            bus.mem_write_en = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl with a behavioural 1-cycle-latency RAM on the memory side.
module tb_oam_dma_ctrl;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   oam_dma_ctrl_if bus();
   oam_dma_ctrl dut (.clk(clk), .rst(rst_n), .bus(bus));

   logic [7:0]  ram [0:65535];
   logic [7:0]  rd_q = 8'h00;
   logic        tb_par;
   logic [7:0]  wq [$];
   logic [15:0] rq [$];
   int total = 0;
   int bad   = 0;

   assign bus.mem_data_rd = rd_q;

   always @(posedge clk) begin
      if (bus.mem_read_en)  rd_q <= ram[bus.mem_addr];
      if (bus.mem_write_en) ram[bus.mem_addr] <= bus.mem_data_wr;
   end

   always @(posedge clk or negedge rst_n)
      if (!rst_n) tb_par <= 1'b0;
      else        tb_par <= ~tb_par;

   always @(negedge clk) begin
      if (rst_n && bus.dma_busy) begin
         if (bus.mem_write_en && bus.mem_addr == 16'h2004) wq.push_back(bus.mem_data_wr);
         if (bus.mem_read_en) rq.push_back(bus.mem_addr);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] pat(input logic [7:0] pg, input logic [7:0] i);
      return (pg == 8'h03) ? (i ^ 8'hA5) : ((i * 8'd3) + 8'd1);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic we, input logic re);
      bus.cpu_mem_addr = a;
      bus.cpu_data_out = d;
      bus.cpu_write_en = we;
      bus.cpu_read_en  = re;
   endtask

   // Waits for the wanted parity, triggers, and checks stall length, data and source addresses.
   task automatic run_dma(input logic [7:0] pg, input bit align, input bit retrig, input string nm);
      int  hcnt    = 0;
      bit  timeout = 1'b1;
      int  derr    = 0;
      int  aerr    = 0;
      wq.delete();
      rq.delete();
      for (int k = 0; k < 4 && tb_par == align; k++) begin
         @(posedge clk); #2;
      end
      drive(16'h4014, pg, 1'b1, 1'b0);
      @(posedge clk); #2;
      drive(16'h0000, 8'h00, 1'b0, 1'b0);
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (bus.cpu_halt) begin
            hcnt++;
            if (retrig && hcnt == 100)      drive(16'h4014, 8'h77, 1'b1, 1'b0);
            else if (retrig && hcnt == 101) drive(16'h0000, 8'h00, 1'b0, 1'b0);
         end else begin
            timeout = 1'b0;
            break;
         end
      end
      chk({nm, " timeout"}, 32'(timeout), 32'd0);
      chk({nm, " bus back to cpu"}, {bus.mem_addr, bus.mem_write_en, bus.mem_read_en, bus.dma_busy},
          {16'h0000, 1'b0, 1'b0, 1'b0});
      chk({nm, " halt cycles"}, 32'(hcnt), align ? 32'd514 : 32'd513);
      chk({nm, " write count"}, 32'(wq.size()), 32'd256);
      chk({nm, " read count"}, 32'(rq.size()), 32'd256);
      for (int i = 0; i < wq.size(); i++)
         if (wq[i] !== pat(pg, 8'(i))) derr++;
      for (int i = 0; i < rq.size(); i++)
         if (rq[i] !== {pg, 8'(i)}) aerr++;
      chk({nm, " data errors"}, 32'(derr), 32'd0);
      chk({nm, " src addr errors"}, 32'(aerr), 32'd0);
   endtask

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  dat;
      logic        we;
      logic        re;
      logic [15:0] exp_addr;
      logic [7:0]  exp_dat;
      logic        exp_we;
      logic        exp_re;
      logic        exp_busy;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{16'h0210, 8'h00, 1'b0, 1'b1, 16'h0210, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{16'h0000, 8'h55, 1'b1, 1'b0, 16'h0000, 8'h55, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{16'h4014, 8'h03, 1'b0, 1'b1, 16'h4014, 8'h03, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{16'h4013, 8'h03, 1'b1, 1'b0, 16'h4013, 8'h03, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{16'h1234, 8'hAA, 1'b0, 1'b0, 16'h1234, 8'hAA, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{16'h4015, 8'h03, 1'b1, 1'b0, 16'h4015, 8'h03, 1'b1, 1'b0, 1'b0};

      for (int i = 0; i < 256; i++) begin
         ram[16'h0300 + i] = pat(8'h03, 8'(i));
         ram[16'hFF00 + i] = pat(8'hFF, 8'(i));
      end

      drive(16'h0210, 8'h00, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      chk("reset halt/busy", {bus.cpu_halt, bus.dma_busy}, 2'b00);
      chk("reset bus follows cpu", {bus.mem_addr, bus.mem_write_en, bus.mem_read_en},
          {16'h0210, 1'b0, 1'b1});
      @(posedge clk); #2;
      rst_n = 1'b1;

      for (int v = 0; v < 6; v++) begin
         @(posedge clk); #2;
         drive(vecs[v].addr, vecs[v].dat, vecs[v].we, vecs[v].re);
         @(negedge clk);
         chk($sformatf("idle vec%0d bus", v),
             {bus.mem_addr, bus.mem_data_wr, bus.mem_write_en, bus.mem_read_en, bus.cpu_halt},
             {vecs[v].exp_addr, vecs[v].exp_dat, vecs[v].exp_we, vecs[v].exp_re, 1'b0});
         @(posedge clk); #2;
         drive(16'h0000, 8'h00, 1'b0, 1'b0);
         chk($sformatf("idle vec%0d busy", v), {bus.dma_busy, bus.cpu_halt},
             {vecs[v].exp_busy, vecs[v].exp_busy});
      end

      run_dma(8'h03, 1'b0, 1'b0, "t1 even");
      run_dma(8'h03, 1'b1, 1'b0, "t2 odd");
      run_dma(8'h03, 1'b0, 1'b1, "t4 retrigger");
      run_dma(8'hFF, 1'b0, 1'b0, "t6 page ff");

      // Reset in the middle of a transfer.
      wq.delete();
      rq.delete();
      @(posedge clk); #2;
      drive(16'h4014, 8'h03, 1'b1, 1'b0);
      @(posedge clk); #2;
      drive(16'h0000, 8'h00, 1'b0, 1'b0);
      for (int k = 0; k < 1000 && wq.size() < 100; k++) begin
         @(negedge clk); #1;
      end
      chk("t5 reached 100 writes", 32'(wq.size() >= 100), 32'd1);
      drive(16'h0123, 8'h00, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t5 async halt/busy", {bus.cpu_halt, bus.dma_busy}, 2'b00);
      chk("t5 bus to cpu", {bus.mem_addr, bus.mem_write_en, bus.mem_read_en}, {16'h0123, 1'b0, 1'b1});
      @(posedge clk); #2;
      drive(16'h0000, 8'h00, 1'b0, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      run_dma(8'h03, 1'b0, 1'b0, "t5 after reset");

      // Trigger coinciding with reset: reset must win.
      @(posedge clk); #2;
      drive(16'h4014, 8'h03, 1'b1, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #2;
      drive(16'h0000, 8'h00, 1'b0, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #2;
      chk("reset beats trigger", {bus.dma_busy, bus.cpu_halt}, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
